// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: data-memory responder with wait states, byte-lane RAM and an MMIO cycle counter / tohost window.
// Ports: i_clk/i_rstn clock and sync active-low reset; i_req_valid/o_req_ready request handshake;
// i_addr/i_write/i_byte_sel/i_wdata request fields; o_rsp_valid/o_rdata/o_misaligned response;
// o_tohost/o_tohost_valid simulation-exit register and its store pulse.
module riscv_dmem_responder #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [XLEN-1:0] MMIO_BASE = 32'h8000_0000
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic [XLEN-1:0] i_addr,
   input  logic            i_write,
   input  logic [3:0]      i_byte_sel,
   input  logic [XLEN-1:0] i_wdata,
   output logic            o_rsp_valid,
   output logic [XLEN-1:0] o_rdata,
   output logic            o_misaligned,
   output logic [XLEN-1:0] o_tohost,
   output logic            o_tohost_valid
);
   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [2:0] WS_M1 = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t          state_q;
   logic [2:0]      cnt_q;
   logic [XLEN-1:0] cyc_q, tohost_q, tohost_d, hold_q, rdata_q, rd_d, off;
   logic            mis_hold_q, th_hold_q, mis_q, th_q;
   logic [XLEN-1:0] mem_q [DEPTH_WORDS];
   logic            accept, legal, is_mmio, th_wr, ram_wr;
   logic [AW-1:0]   idx;
   assign o_req_ready    = i_rstn && state_q != WAIT;
   assign o_rsp_valid    = state_q == RESP;
   assign o_rdata        = rdata_q;
   assign o_misaligned   = mis_q;
   assign o_tohost       = tohost_q;
   assign o_tohost_valid = th_q;
   always_comb begin
      accept  = i_req_valid && o_req_ready;
      // unsigned wrap makes a single compare cover both window bounds
      off     = i_addr - MMIO_BASE;
      is_mmio = off < XLEN'(8);
      idx     = i_addr[AW+1:2];
      legal   = i_byte_sel inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
      th_wr   = accept && i_write && legal && is_mmio && off[2];
      ram_wr  = accept && i_write && legal && !is_mmio;
      rd_d    = (!legal || i_write) ? '0 : !is_mmio ? mem_q[idx] : off[2] ? tohost_q : cyc_q;
      for (int i = 0; i < 4; i++)
         tohost_d[8*i +: 8] = (th_wr && i_byte_sel[i]) ? i_wdata[8*i +: 8] : tohost_q[8*i +: 8];
   end
   always_ff @(posedge i_clk) begin
      if (ram_wr)
         for (int i = 0; i < 4; i++)
            if (i_byte_sel[i]) mem_q[idx][8*i +: 8] <= i_wdata[8*i +: 8];
   end
   // response fields are staged at acceptance and only exposed on entry to RESP
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cyc_q      <= '0;
         tohost_q   <= '0;
         hold_q     <= '0;
         mis_hold_q <= 1'b0;
         th_hold_q  <= 1'b0;
         rdata_q    <= '0;
         mis_q      <= 1'b0;
         th_q       <= 1'b0;
      end else begin
         cyc_q    <= cyc_q + 1'b1;
         tohost_q <= tohost_d;
         th_q     <= 1'b0;
         if (accept) begin
            hold_q     <= rd_d;
            mis_hold_q <= !legal;
            th_hold_q  <= th_wr;
         end
         if (accept && WAIT_STATES != 0) begin
            state_q <= WAIT;
            cnt_q   <= WS_M1;
         end else if (accept || (state_q == WAIT && cnt_q == 3'd0)) begin
            state_q <= RESP;
            rdata_q <= accept ? rd_d : hold_q;
            mis_q   <= accept ? !legal : mis_hold_q;
            th_q    <= accept ? th_wr : th_hold_q;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - 3'd1;
         end else begin
            state_q <= IDLE;
         end
      end
   end
endmodule

// File: doc/riscv_dmem_responder.md
# riscv_dmem_responder

Data-memory responder on the load/store side of the pipelined core: it accepts the core's memory-stage requests (address, write strobe, byte-lane select, write data) and returns read data. It holds a word-organised data RAM with byte-lane writes, a programmable wait-state counter with a ready/valid handshake, and a small MMIO window holding a free-running cycle counter and a `tohost` register for simulation exit. Sign/zero extension of loads stays in the core; this block always returns the full 32-bit word.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `WAIT_STATES`, 0: extra cycles between request acceptance and response; range 0..7.
- `MMIO_BASE`, 32'h8000_0000: start of the MMIO window; the window is 8 bytes.
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rstn`  in  1  reset, synchronous, active-low.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  block can accept a request this cycle.
- `i_addr`  in  `XLEN`  byte address; bits [1:0] ignored.
- `i_write`  in  1  1 = store, 0 = load.
- `i_byte_sel`  in  4  lane mask; bit n enables byte lane n.
- `i_wdata`  in  `XLEN`  lane-aligned store data.
- `o_rsp_valid`  out  1  one-cycle response pulse.
- `o_rdata`  out  `XLEN`  load data; valid while `o_rsp_valid`=1.
- `o_misaligned`  out  1  error qualifier; valid while `o_rsp_valid`=1.
- `o_tohost`  out  `XLEN`  last value stored to MMIO offset 4.
- `o_tohost_valid`  out  1  one-cycle pulse with the response of a `tohost` store.

## Operation
- Handshake: a request is accepted on a rising edge where `i_req_valid` and `o_req_ready` are both 1. All request fields are sampled on that edge.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `o_req_ready`=1. On acceptance, go to WAIT with counter=`WAIT_STATES`-1 if `WAIT_STATES`>0; otherwise go to RESP.
  - WAIT: `o_req_ready`=0. Decrement the counter; go to RESP when it is 0.
  - RESP: `o_rsp_valid`=1 and `o_req_ready`=1. An acceptance in RESP follows the same rules as in IDLE, which allows back-to-back requests. With no acceptance, go to IDLE.
- Legal masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other mask, including 0000, is misaligned: no write, `o_rdata`=0, `o_misaligned`=1.
- Address decode:
  - MMIO when `MMIO_BASE` <= `i_addr` < `MMIO_BASE`+8.
  - Otherwise RAM, with index = `i_addr`[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses alias and wrap.
- RAM store: the enabled lanes are written on the acceptance edge. The response carries `o_rdata`=0.
- RAM load: the word is read on the acceptance edge into a response register. Because the write commits at acceptance, a load accepted after a store sees the store's data.
- MMIO offset 0: cycle counter, read-only; stores are ignored without error. The counter is 32 bits, is 0 on the first cycle after reset, increments every cycle and wraps. A load returns its value at the acceptance edge.
- MMIO offset 4 (`tohost`): a store with a legal mask updates only the enabled lanes of `o_tohost`. `o_tohost_valid` pulses in the response cycle. A load returns `o_tohost`.
- A misaligned MMIO access has no side effect.
- RAM contents are not initialised or cleared by reset.

## Timing
- Response latency: `o_rsp_valid` rises exactly `WAIT_STATES`+1 cycles after the acceptance edge.
- Throughput: with `WAIT_STATES`=0, one request per cycle. Otherwise one request per `WAIT_STATES`+1 cycles.
- `o_rdata` and `o_misaligned` are registered and hold their value until the next response.
- While `i_rstn`=0 on an edge:
  - State becomes IDLE, counter 0, cycle counter 0, `o_tohost` 0.
  - `o_rsp_valid`, `o_tohost_valid`, `o_misaligned` and `o_rdata` are all 0.
  - `o_req_ready` is 0 while `i_rstn`=0 (gated).
- Reset in WAIT or RESP drops the in-flight response: no `o_rsp_valid` follows.
- A RAM store whose acceptance edge preceded reset remains written.

## Test plan
- Full-word write/read, `WAIT_STATES`=0:
  - Store 0xDEADBEEF, mask 1111, to 0x10; then load 0x10 on the next cycle.
  - Required: `o_rsp_valid` on consecutive cycles, second `o_rdata`=0xDEADBEEF, `o_misaligned`=0.
- Byte and halfword lanes:
  - Over word 0x11223344 at 0x20, store 0xAA000000 with mask 1000, then 0x00005566 with mask 0011.
  - Required: a load of 0x20 returns 0xAA225566.
- Misaligned mask:
  - Store with mask 0110 to 0x20.
  - Required: `o_misaligned`=1, `o_rdata`=0, and a later load of 0x20 is unchanged.
- Wait states, `WAIT_STATES`=3:
  - Accept at edge N.
  - Required: `o_req_ready`=0 on cycles N+1..N+3, `o_rsp_valid`=1 only on cycle N+4, a second request accepted at N+4.
- MMIO:
  - Store 1 to `MMIO_BASE`+4. Required: `o_tohost`=1 and a single-cycle `o_tohost_valid`.
  - Two loads of `MMIO_BASE` accepted 5 cycles apart. Required: returned values differ by 5.
  - Aliasing: with `DEPTH_WORDS`=1024, a store to 0x1000 is readable at 0x0.
- Reset mid-operation, `WAIT_STATES`=2:
  - Drop `i_rstn` one cycle after acceptance.
  - Required: no `o_rsp_valid`, all outputs 0, `o_req_ready`=1 on the first cycle after `i_rstn` returns high.
